// File: rtl/ascon_final.sv
// ascon_final: Ascon-128 finalization engine.
// Loads the post-absorption state, folds the key into x1/x2, runs the
// 12-round Ascon-p permutation one round per clock and emits the tag
// {x3^K0, x4^K1} together with a one-cycle completion pulse/interrupt.
// Optional build macro ASCON_TAG_VERIFY_EN adds exp_tag_i/tag_ok_o and the
// on-chip tag comparison; without it those ports and registers do not exist.
module ascon_final (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [4:0][63:0] state_i,
    input  logic [127:0]     key_i,
`ifdef ASCON_TAG_VERIFY_EN
    input  logic [127:0]     exp_tag_i,
    output logic             tag_ok_o,
`endif
    output logic             busy_o,
    output logic [4:0][63:0] state_o,
    output logic             update_state_o,
    output logic [127:0]     tag_o,
    output logic             tag_valid_o,
    output logic             finished_o,
    output logic             ascon_intr_o
);

    typedef enum logic {IDLE, BUSY} fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'd11;

    fsm_t             fsm_q;
    logic [3:0]       round_q;
    logic [127:0]     key_q;
    logic [4:0][63:0] round_nxt;
    logic [127:0]     tag_nxt;
`ifdef ASCON_TAG_VERIFY_EN
    logic [127:0]     exp_tag_q;
`endif

    // 64-bit rotate right by a fixed amount.
    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One Ascon-p round: constant addition, bitsliced 5-bit S-box, linear layer.
    function automatic logic [4:0][63:0] p_round(input logic [4:0][63:0] s,
                                                 input logic [3:0]       r);
        logic [63:0]      x0, x1, x2, x3, x4;
        logic [63:0]      t0, t1, t2, t3, t4;
        logic [4:0][63:0] o;
        x0 = s[0];
        x1 = s[1];
        x2 = s[2] ^ {56'd0, 4'hF - r, r};
        x3 = s[3];
        x4 = s[4];
        // S-box, bitsliced across all 64 columns
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        // linear diffusion layer, one rotation pair per word
        o[0] = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        o[1] = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        o[2] = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        o[3] = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        o[4] = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        return o;
    endfunction

    // The round result and the tag it would yield, using the captured key.
    assign round_nxt = p_round(state_o, round_q);
    assign tag_nxt   = {round_nxt[3] ^ key_q[127:64], round_nxt[4] ^ key_q[63:0]};

    // The interrupt is the completion pulse itself.
    assign ascon_intr_o = finished_o;

    // Control FSM, round counter, state register and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fsm_q          <= IDLE;
            round_q        <= 4'd0;
            key_q          <= '0;
            state_o        <= '0;
            tag_o          <= '0;
            tag_valid_o    <= 1'b0;
            finished_o     <= 1'b0;
            busy_o         <= 1'b0;
            update_state_o <= 1'b0;
`ifdef ASCON_TAG_VERIFY_EN
            exp_tag_q      <= '0;
            tag_ok_o       <= 1'b0;
`endif
        end else begin
            finished_o <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start_i) begin
                        state_o[0]     <= state_i[0];
                        state_o[1]     <= state_i[1] ^ key_i[127:64];
                        state_o[2]     <= state_i[2] ^ key_i[63:0];
                        state_o[3]     <= state_i[3];
                        state_o[4]     <= state_i[4];
                        key_q          <= key_i;
                        round_q        <= 4'd0;
                        tag_valid_o    <= 1'b0;
                        busy_o         <= 1'b1;
                        update_state_o <= 1'b1;
                        fsm_q          <= BUSY;
`ifdef ASCON_TAG_VERIFY_EN
                        exp_tag_q      <= exp_tag_i;
                        tag_ok_o       <= 1'b0;
`endif
                    end
                end
                BUSY: begin
                    state_o <= round_nxt;
                    round_q <= round_q + 4'd1;
                    if (round_q == LAST_ROUND) begin
                        round_q        <= 4'd0;
                        tag_o          <= tag_nxt;
                        tag_valid_o    <= 1'b1;
                        finished_o     <= 1'b1;
                        busy_o         <= 1'b0;
                        update_state_o <= 1'b0;
                        fsm_q          <= IDLE;
`ifdef ASCON_TAG_VERIFY_EN
                        tag_ok_o       <= (tag_nxt == exp_tag_q);
`endif
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule
